// File: rtl/prefix_sub.sv
// Two-stage pipelined 8-bit subtractor a - b - bin built on a Kogge-Stone carry network.
// Define PREFIX_SUB_SAT_EN to clamp d to 8'h00 whenever the unsigned result borrows.
module prefix_sub (
    input  logic       clk,
    input  logic       rst,
    input  logic       in_valid,
    output logic       in_ready,
    input  logic [7:0] a,
    input  logic [7:0] b,
    input  logic       bin,
    output logic       out_valid,
    input  logic       out_ready,
    output logic [7:0] d,
    output logic       bout,
    output logic       ovf
);

    // Stage 1: per-bit propagate/generate of a + ~b, carry-in, sign bits
    logic       v1_q, v1_d;
    logic [7:0] p_q, p_d;
    logic [7:0] g_q, g_d;
    logic       cin_q, cin_d;
    logic       a7_q, a7_d;
    logic       b7_q, b7_d;

    // Stage 2: final result
    logic       v2_q, v2_d;
    logic [7:0] diff_q, diff_d;
    logic       bout_q, bout_d;
    logic       ovf_q, ovf_d;

    logic       ld2, ld1;

    logic [7:0] g0, p0, g1, p1, g2, p2, g3;
    logic [7:0] carry_in;
    logic [7:0] sum;
    logic       carry_out;

    always_comb begin
        ld2      = !v2_q || out_ready;
        ld1      = !v1_q || ld2;
        in_ready = ld1;
    end

    // Fold the carry-in into bit 0 so the prefix tree only sees (p,g) pairs
    always_comb begin
        g0        = g_q;
        g0[0]     = g_q[0] | (p_q[0] & cin_q);
        p0        = p_q;
        g1        = g0 | (p0 & {g0[6:0], 1'b0});
        p1        = p0 & {p0[6:0], 1'b1};
        g2        = g1 | (p1 & {g1[5:0], 2'b00});
        p2        = p1 & {p1[5:0], 2'b11};
        g3        = g2 | (p2 & {g2[3:0], 4'b0000});
        carry_in  = {g3[6:0], cin_q};
        sum       = p_q ^ carry_in;
        carry_out = g3[7];
    end

    always_comb begin
        v1_d  = v1_q;
        p_d   = p_q;
        g_d   = g_q;
        cin_d = cin_q;
        a7_d  = a7_q;
        b7_d  = b7_q;
        if (ld1) begin
            v1_d = in_valid;
            if (in_valid) begin
                p_d   = a ^ ~b;
                g_d   = a & ~b;
                cin_d = ~bin;
                a7_d  = a[7];
                b7_d  = b[7];
            end
        end
    end

    always_comb begin
        v2_d   = v2_q;
        diff_d = diff_q;
        bout_d = bout_q;
        ovf_d  = ovf_q;
        if (ld2) begin
            v2_d = v1_q;
            if (v1_q) begin
`ifdef PREFIX_SUB_SAT_EN
                diff_d = carry_out ? sum : 8'h00;
`else
                diff_d = sum;
`endif
                bout_d = ~carry_out;
                ovf_d  = (a7_q != b7_q) && (sum[7] != a7_q);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            v1_q   <= 1'b0;
            p_q    <= 8'h00;
            g_q    <= 8'h00;
            cin_q  <= 1'b0;
            a7_q   <= 1'b0;
            b7_q   <= 1'b0;
            v2_q   <= 1'b0;
            diff_q <= 8'h00;
            bout_q <= 1'b0;
            ovf_q  <= 1'b0;
        end else begin
            v1_q   <= v1_d;
            p_q    <= p_d;
            g_q    <= g_d;
            cin_q  <= cin_d;
            a7_q   <= a7_d;
            b7_q   <= b7_d;
            v2_q   <= v2_d;
            diff_q <= diff_d;
            bout_q <= bout_d;
            ovf_q  <= ovf_d;
        end
    end

    always_comb begin
        out_valid = v2_q;
        d         = diff_q;
        bout      = bout_q;
        ovf       = ovf_q;
    end

endmodule

// File: tb/tb_prefix_sub.sv
// Self-checking bench for prefix_sub: directed vectors, backpressure, reset flush and
// randomized traffic against an arithmetic reference model.
module tb_prefix_sub;

    logic       clk = 1'b0;
    logic       rst;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] a;
    logic [7:0] b;
    logic       bin;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] d;
    logic       bout;
    logic       ovf;

    int n_cmp = 0;
    int n_err = 0;

    prefix_sub dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .bin       (bin),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .d         (d),
        .bout      (bout),
        .ovf       (ovf)
    );

    always #5 clk = ~clk;

    // Expected {d, bout, ovf} from plain integer subtraction
    function automatic logic [9:0] model(input logic [7:0] ma, input logic [7:0] mb,
                                         input logic mbin);
        int ud, sd, sa, sb;
        logic [7:0] rd;
        logic rb, ro;
        sa = $signed(ma);
        sb = $signed(mb);
        ud = int'(ma) - int'(mb) - int'(mbin);
        sd = sa - sb - int'(mbin);
        rd = ud[7:0];
        rb = (ud < 0);
        ro = (sd < -128) || (sd > 127);
`ifdef PREFIX_SUB_SAT_EN
        if (rb) rd = 8'h00;
`endif
        return {rd, rb, ro};
    endfunction

    task automatic drive(input logic iv, input logic [7:0] ia, input logic [7:0] ib,
                         input logic ibin, input logic ordy);
        in_valid  = iv;
        a         = ia;
        b         = ib;
        bin       = ibin;
        out_ready = ordy;
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        drive(1'b0, 8'h00, 8'h00, 1'b0, 1'b0);
        #2;
        n_cmp++;
        if ({out_valid, d, bout, ovf} !== 11'b0) begin
            n_err++;
            $display("FAIL reset_outputs: got %b want 0", {out_valid, d, bout, ovf});
        end
        @(posedge clk);
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        n_cmp++;
        if (in_ready !== 1'b1) begin
            n_err++;
            $display("FAIL reset_in_ready: got %b want 1", in_ready);
        end
        next_cycle();
    endtask

    task automatic test_directed();
        logic [7:0] va [4];
        logic [7:0] vb [4];
        logic       vbin [4];
        logic [9:0] exp_v [4];
        va = '{8'h05, 8'h00, 8'h80, 8'h10};
        vb = '{8'h03, 8'h01, 8'h01, 8'h0F};
        vbin = '{1'b0, 1'b0, 1'b0, 1'b1};
`ifdef PREFIX_SUB_SAT_EN
        exp_v = '{{8'h02, 2'b00}, {8'h00, 2'b10}, {8'h7F, 2'b01}, {8'h00, 2'b00}};
`else
        exp_v = '{{8'h02, 2'b00}, {8'hFF, 2'b10}, {8'h7F, 2'b01}, {8'h00, 2'b00}};
`endif
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, va[i], vb[i], vbin[i], 1'b1);
            @(negedge clk);
            n_cmp++;
            if (in_ready !== 1'b1) begin
                n_err++;
                $display("FAIL directed_accept[%0d]: in_ready=%b want 1", i, in_ready);
            end
            next_cycle();
            drive(1'b0, 8'h00, 8'h00, 1'b0, 1'b1);
            @(negedge clk);
            n_cmp++;
            if (out_valid !== 1'b0) begin
                n_err++;
                $display("FAIL directed_latency1[%0d]: out_valid=%b want 0", i, out_valid);
            end
            next_cycle();
            @(negedge clk);
            n_cmp++;
            if (out_valid !== 1'b1 || {d, bout, ovf} !== exp_v[i]) begin
                n_err++;
                $display("FAIL directed_result[%0d]: valid=%b d=%h bout=%b ovf=%b want d=%h bout=%b ovf=%b",
                         i, out_valid, d, bout, ovf, exp_v[i][9:2], exp_v[i][1], exp_v[i][0]);
            end
            next_cycle();
        end
    endtask

    task automatic test_backpressure();
        logic [7:0] sa [3];
        logic [7:0] sb [3];
        logic       sbin [3];
        logic [9:0] held;
        int got;
        int idx;
        for (int i = 0; i < 3; i++) begin
            sa[i] = 8'($urandom);
            sb[i] = 8'($urandom);
            sbin[i] = 1'($urandom);
        end
        for (int i = 0; i < 2; i++) begin
            drive(1'b1, sa[i], sb[i], sbin[i], 1'b0);
            @(negedge clk);
            n_cmp++;
            if (in_ready !== 1'b1) begin
                n_err++;
                $display("FAIL bp_accept[%0d]: in_ready=%b want 1", i, in_ready);
            end
            next_cycle();
        end
        // Full pipeline: junk offers must be ignored and output must hold
        held = model(sa[0], sb[0], sbin[0]);
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 8'($urandom), 8'($urandom), 1'($urandom), 1'b0);
            @(negedge clk);
            n_cmp++;
            if (in_ready !== 1'b0 || out_valid !== 1'b1 || {d, bout, ovf} !== held) begin
                n_err++;
                $display("FAIL bp_stall[%0d]: in_ready=%b valid=%b out=%h want 0 1 %h",
                         i, in_ready, out_valid, {d, bout, ovf}, held);
            end
            next_cycle();
        end
        got = 0;
        idx = 2;
        for (int cyc = 0; cyc < 12; cyc++) begin
            if (idx < 3) drive(1'b1, sa[idx], sb[idx], sbin[idx], 1'b1);
            else drive(1'b0, 8'h00, 8'h00, 1'b0, 1'b1);
            @(negedge clk);
            if (in_valid && in_ready) idx++;
            if (out_valid) begin
                n_cmp++;
                if (got >= 3) begin
                    n_err++;
                    $display("FAIL bp_extra: unexpected result d=%h", d);
                end else if ({d, bout, ovf} !== model(sa[got], sb[got], sbin[got])) begin
                    n_err++;
                    $display("FAIL bp_order[%0d]: got %h want %h", got, {d, bout, ovf},
                             model(sa[got], sb[got], sbin[got]));
                end
                got++;
            end
            next_cycle();
        end
        n_cmp++;
        if (got !== 3 || idx !== 3) begin
            n_err++;
            $display("FAIL bp_count: results=%0d accepted=%0d want 3 3", got, idx);
        end
    endtask

    task automatic test_reset_midflight();
        logic stale;
        for (int i = 0; i < 2; i++) begin
            drive(1'b1, 8'($urandom), 8'($urandom), 1'($urandom), 1'b0);
            next_cycle();
        end
        drive(1'b0, 8'h00, 8'h00, 1'b0, 1'b0);
        @(negedge clk);
        n_cmp++;
        if (out_valid !== 1'b1 || in_ready !== 1'b0) begin
            n_err++;
            $display("FAIL rstmid_full: valid=%b in_ready=%b want 1 0", out_valid, in_ready);
        end
        #1;
        rst = 1'b1;
        #1;
        n_cmp++;
        if ({out_valid, d, bout, ovf} !== 11'b0) begin
            n_err++;
            $display("FAIL rstmid_async: got %b want 0", {out_valid, d, bout, ovf});
        end
        next_cycle();
        rst = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        n_cmp++;
        if (in_ready !== 1'b1) begin
            n_err++;
            $display("FAIL rstmid_in_ready: got %b want 1", in_ready);
        end
        stale = 1'b0;
        for (int i = 0; i < 4; i++) begin
            if (out_valid !== 1'b0) stale = 1'b1;
            next_cycle();
            @(negedge clk);
        end
        n_cmp++;
        if (stale !== 1'b0) begin
            n_err++;
            $display("FAIL rstmid_stale: stale result seen=%b want 0", stale);
        end
        next_cycle();
    endtask

    task automatic test_random();
        logic [9:0] q[$];
        logic [9:0] held;
        logic       held_valid;
        logic [9:0] exp_r;
        int sent;
        int got;
        sent = 0;
        got = 0;
        held_valid = 1'b0;
        held = '0;
        for (int cyc = 0; cyc < 60000 && got < 10000; cyc++) begin
            drive((sent < 10000) && ($urandom_range(0, 3) != 0), 8'($urandom), 8'($urandom),
                  1'($urandom), 1'($urandom));
            @(negedge clk);
            if (held_valid) begin
                n_cmp++;
                if (out_valid !== 1'b1 || {d, bout, ovf} !== held) begin
                    n_err++;
                    $display("FAIL rand_hold: valid=%b out=%h want 1 %h", out_valid,
                             {d, bout, ovf}, held);
                end
            end
            if (in_valid && in_ready) begin
                q.push_back(model(a, b, bin));
                sent++;
            end
            if (out_valid && out_ready) begin
                n_cmp++;
                if (q.size() == 0) begin
                    n_err++;
                    $display("FAIL rand_spurious: result %h with empty model queue",
                             {d, bout, ovf});
                end else begin
                    exp_r = q.pop_front();
                    if ({d, bout, ovf} !== exp_r) begin
                        n_err++;
                        $display("FAIL rand_result[%0d]: got %h want %h", got, {d, bout, ovf},
                                 exp_r);
                    end
                end
                got++;
            end
            held_valid = out_valid && !out_ready;
            held = {d, bout, ovf};
            next_cycle();
        end
        n_cmp++;
        if (got != 10000 || q.size() != 0) begin
            n_err++;
            $display("FAIL rand_count: results=%0d pending=%0d want 10000 0", got, q.size());
        end
        drive(1'b0, 8'h00, 8'h00, 1'b0, 1'b1);
    endtask

    initial begin
        test_reset();
        test_directed();
        test_backpressure();
        test_reset_midflight();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/prefix_sub.md
PREFIX_SUB -- requirements
Module: prefix_sub

Interface
Parameters: none; operand width fixed at 8 bits.
REQ-001 The block SHALL have: clk  input  1  sole clock, all state updates on rising edge.
REQ-002 The block SHALL have: rst  input  1  reset, asynchronous, active-high.
REQ-003 The block SHALL have: in_valid  input  1  operand set a/b/bin present.
REQ-004 The block SHALL have: in_ready  output  1  block accepts operands this cycle.
REQ-005 The block SHALL have: a  input  8  minuend, unsigned or two's-complement.
REQ-006 The block SHALL have: b  input  8  subtrahend.
REQ-007 The block SHALL have: bin  input  1  borrow-in.
REQ-008 The block SHALL have: out_valid  output  1  result d/bout/ovf present.
REQ-009 The block SHALL have: out_ready  input  1  downstream accepts result.
REQ-010 The block SHALL have: d  output  8  difference.
REQ-011 The block SHALL have: bout  output  1  unsigned borrow-out.
REQ-012 The block SHALL have: ovf  output  1  signed two's-complement overflow.

Function
REQ-013 The block SHALL compute d = a - b - bin as a + ~b + ~bin modulo 256.
REQ-014 The carries SHALL be formed by a log-depth parallel-prefix network of (p,g) combine cells, no ripple chain; ~bin enters as carry-in.
REQ-015 bout SHALL equal the inverse of the bit-7 carry-out; ovf SHALL be 1 iff a[7] != b[7] and the wrapped d[7] != a[7].
REQ-016 The datapath SHALL be two register stages: stage 1 captures per-bit p/g of (a, ~b) plus carry-in and a[7]/b[7]; stage 2 captures d, bout, ovf.
REQ-017 Input transfer occurs on in_valid && in_ready; output transfer on out_valid && out_ready.
REQ-018 Latency SHALL be exactly 2 cycles from input transfer to out_valid when out_ready is held high; throughput one result per cycle.
REQ-019 Stage 2 SHALL load when empty or transferring out in the same cycle; stage 1 SHALL load when empty or advancing into stage 2 in the same cycle.
REQ-020 in_ready SHALL be 1 iff stage 1 can load this cycle (combinational from out_ready and stage valids allowed).
REQ-021 With out_ready low and both stages full, in_ready SHALL be 0; no result SHALL be lost, duplicated or reordered.
REQ-022 While out_valid=1 and out_ready=0, d/bout/ovf SHALL hold stable.
REQ-023 Simultaneous output transfer and input transfer with both stages full SHALL shift the pipeline with no bubble.
REQ-024 in_valid, a, b, bin SHALL be ignored when in_ready=0.

Reset
REQ-025 rst high SHALL immediately clear both stage valid flags regardless of clock; out_valid=0, d=8'h00, bout=0, ovf=0.
REQ-026 In-flight operands at reset SHALL be discarded; in_ready SHALL be 1 in the first cycle after rst deasserts.

Configuration
REQ-027 Macro PREFIX_SUB_SAT_EN, when defined, SHALL make d=8'h00 whenever bout=1 (unsigned floor saturation); bout and ovf unchanged.
REQ-028 Without PREFIX_SUB_SAT_EN, d SHALL be the wrapped modulo-256 difference; handshake and latency identical in both builds.

Verification
REQ-029 a=0x05,b=0x03,bin=0, out_ready=1 -> two cycles later d=0x02, bout=0, ovf=0.
REQ-030 a=0x00,b=0x01,bin=0 -> d=0xFF, bout=1, ovf=0 (d=0x00 with PREFIX_SUB_SAT_EN).
REQ-031 a=0x80,b=0x01,bin=0 -> d=0x7F, bout=0, ovf=1; a=0x10,b=0x0F,bin=1 -> d=0x00, bout=0.
REQ-032 out_ready=0, offer 3 back-to-back sets -> 2 accepted, in_ready=0 after the second; raise out_ready -> results in order, third accepted, none lost.
REQ-033 rst pulsed with both stages full -> out_valid=0 during reset, in_ready=1 first cycle after, no stale result emitted.
REQ-034 Random 10k operand sets with random out_ready -> every result matches a-b-bin reference model in order.
